sram_march_bist: RTL

Built-in self-test initiator for the sky130 1kbyte 1rw1r 32x256 SRAM macro. It drives both macro ports from a single clock: port 0 handles write and read, port 1 is read-only. It runs a fixed March C- style sequence, checks every read word against the expected pattern, and reports pass/fail with first-failure details. It sits beside the SRAM wrapper and owns the macro pins whenever a test is running; an upstream mux selects it during test.

---
 rtl/sram_bist_pkg.sv | 54 +++++
 rtl/sram_march_bist_if.sv | 20 ++
 rtl/sram_bist_checker.sv | 61 ++++++
 rtl/sram_march_bist.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM March C- BIST: FSM states, element codes and the
// read-check record that travels down the checker pipe.
package sram_bist_pkg;
  localparam int BIST_ADDR_W = 8;
  localparam int BIST_DATA_W = 32;

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  typedef logic [2:0] elem_t;
  localparam elem_t EL_M0 = 3'd0;
  localparam elem_t EL_M1 = 3'd1;
  localparam elem_t EL_M2 = 3'd2;
  localparam elem_t EL_M3 = 3'd3;
  localparam elem_t EL_M4 = 3'd4;
  localparam elem_t EL_M5 = 3'd5;

  typedef struct packed {
    elem_t                  elem;
    logic [BIST_ADDR_W-1:0] addr;
    logic [BIST_DATA_W-1:0] expected;
    logic                   port;
  } chk_rec_t;

  function automatic elem_t st_elem(state_t s);
    case (s)
      M1:      return EL_M1;
      M2:      return EL_M2;
      M3:      return EL_M3;
      M4:      return EL_M4;
      M5:      return EL_M5;
      default: return EL_M0;
    endcase
  endfunction

  function automatic state_t st_next(state_t s);
    case (s)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return DRAIN;
    endcase
  endfunction

  // M3..M5 walk the array downwards
  function automatic logic el_desc(elem_t e);
    return e >= EL_M3;
  endfunction

  function automatic logic el_rw(elem_t e);
    return (e != EL_M0) && (e != EL_M5);
  endfunction
endpackage

// File: rtl/sram_march_bist_if.sv
// Macro-side pins of the 1rw1r SRAM: port 0 read/write, port 1 read-only.
interface sram_march_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                csb0;
  logic                web0;
  logic [DATA_W/8-1:0] wmask0;
  logic [ADDR_W-1:0]   addr0;
  logic [DATA_W-1:0]   din0;
  logic [DATA_W-1:0]   dout0;
  logic                csb1;
  logic [ADDR_W-1:0]   addr1;
  logic [DATA_W-1:0]   dout1;

  modport master (output csb0, web0, wmask0, addr0, din0, csb1, addr1,
                  input  dout0, dout1);
  modport slave  (input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
                  output dout0, dout1);
endinterface

// File: rtl/sram_bist_checker.sv
// Read-data checker: delays each read record by RD_LAT, compares the selected
// port's dout against it and keeps the first failure plus a sticky ok flag.
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_vld,
  input  chk_rec_t          rd_rec,
  input  logic [DATA_W-1:0] dout0,
  input  logic [DATA_W-1:0] dout1,
  output logic              ok,
  output elem_t             fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  logic [RD_LAT:1]   vld_pipe;
  chk_rec_t          rec_pipe [1:RD_LAT];
  chk_rec_t          ex;
  logic [DATA_W-1:0] rdata;
  logic              miss;

  assign ex    = rec_pipe[RD_LAT];
  assign rdata = ex.port ? dout1 : dout0;
  assign miss  = vld_pipe[RD_LAT] && (rdata != ex.expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= RD_LAT; i++) rec_pipe[i] <= '0;
      ok        <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      vld_pipe[1] <= rd_vld;
      rec_pipe[1] <= rd_rec;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rec_pipe[i] <= rec_pipe[i-1];
      end
      // ok doubles as "no failure captured yet", so only the first miss latches
      if (clr) begin
        ok        <= 1'b1;
        fail_elem <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (miss && ok) begin
        ok        <= 1'b0;
        fail_elem <= ex.elem;
        fail_addr <= ex.addr;
        fail_data <= rdata;
      end
    end
  end
endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for the 32x256 1rw1r SRAM: FSM, address walk and
// registered port drivers; read checking lives in sram_bist_checker.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int                ADDR_W  = BIST_ADDR_W,
  parameter int                DATA_W  = BIST_DATA_W,
  parameter int                DEPTH   = 2**ADDR_W,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] PATTERN = 32'h5555_AAAA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output elem_t             fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  sram_march_bist_if.master mem
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam int                CNT_W    = $clog2(RD_LAT + 1) + 1;

  // one access cycle worth of port pins plus its check record
  typedef struct packed {
    logic                csb0;
    logic                web0;
    logic [DATA_W/8-1:0] wmask0;
    logic [ADDR_W-1:0]   addr0;
    logic [DATA_W-1:0]   din0;
    logic                csb1;
    logic [ADDR_W-1:0]   addr1;
    logic                rd;
    chk_rec_t            rec;
  } step_t;

  function automatic step_t idle_step();
    step_t s = '0;
    s.csb0 = 1'b1;
    s.web0 = 1'b1;
    s.csb1 = 1'b1;
    return s;
  endfunction

  function automatic step_t issue(elem_t e, logic [ADDR_W-1:0] a, logic wr_ph);
    step_t s = idle_step();
    if (e == EL_M5) begin
      s.csb1  = 1'b0;
      s.addr1 = a;
    end else begin
      s.csb0  = 1'b0;
      s.addr0 = a;
      if (wr_ph || e == EL_M0) begin
        s.web0   = 1'b0;
        s.wmask0 = '1;
        s.din0   = e[0] ? ~PATTERN : PATTERN;
      end
    end
    if (e != EL_M0 && !wr_ph) begin
      s.rd           = 1'b1;
      s.rec.elem     = e;
      s.rec.addr     = a;
      s.rec.expected = e[0] ? PATTERN : ~PATTERN;
      s.rec.port     = (e == EL_M5);
    end
    return s;
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(elem_t e);
    return el_desc(e) ? ADDR_MAX : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] last_addr(elem_t e);
    return el_desc(e) ? '0 : ADDR_MAX;
  endfunction

  state_t            state;
  elem_t             el;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic              ph;
  logic [CNT_W-1:0]  dcnt;
  step_t             acc;
  logic              clr;
  logic              chk_ok;

  assign el       = st_elem(state);
  assign nxt_addr = el_desc(el) ? addr - 1'b1 : addr + 1'b1;
  assign clr      = start && (state == IDLE || state == DONE);

  // acc always holds the access being driven this cycle; outputs come straight from it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      ph    <= 1'b0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= idle_step();
    end else begin
      acc <= idle_step();
      case (state)
        IDLE, DONE: if (start) begin
          state <= M0;
          addr  <= '0;
          ph    <= 1'b0;
          busy  <= 1'b1;
          done  <= 1'b0;
          acc   <= issue(EL_M0, '0, 1'b0);
        end
        DRAIN: if (dcnt == CNT_W'(RD_LAT)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        default: if (el_rw(el) && !ph) begin
          ph  <= 1'b1;
          acc <= issue(el, addr, 1'b1);
        end else begin
          ph <= 1'b0;
          if (addr != last_addr(el)) begin
            addr <= nxt_addr;
            acc  <= issue(el, nxt_addr, 1'b0);
          end else if (state == M5) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            state <= st_next(state);
            addr  <= first_addr(el + 3'd1);
            acc   <= issue(el + 3'd1, first_addr(el + 3'd1), 1'b0);
          end
        end
      endcase
    end
  end

  assign mem.csb0   = acc.csb0;
  assign mem.web0   = acc.web0;
  assign mem.wmask0 = acc.wmask0;
  assign mem.addr0  = acc.addr0;
  assign mem.din0   = acc.din0;
  assign mem.csb1   = acc.csb1;
  assign mem.addr1  = acc.addr1;
  assign pass       = done & chk_ok;

  sram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .rd_vld    (acc.rd),
    .rd_rec    (acc.rec),
    .dout0     (mem.dout0),
    .dout1     (mem.dout1),
    .ok        (chk_ok),
    .fail_elem (fail_elem),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );
endmodule
